// File: rtl/controller_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// ALU funct codes, memory access sizes, trap causes and the strobe bundle.
package controller_mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_RTYPE, CL_IMM, CL_BRANCH, CL_LOAD, CL_STORE, CL_J, CL_JAL, CL_ILLEGAL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       reg_dest;
      logic       mem_to_reg;
      logic       is_signed;
      logic       alu_src;
      logic       jump;
      logic       jal;
      logic       branch;
      logic       eq;
      logic       mem_read;
      logic       mem_write;
      logic       mem_is_signed;
      logic [1:0] mem_size;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_exc;
      logic       trap;
      logic       instr_done;
   } ctl_t;

endpackage

// File: rtl/controller_mc_decode.sv
// Combinational opcode classifier: instruction class, EXEC-stage ALU setup,
// memory access size/sign and the illegal-opcode flag.
module controller_mc_decode
   import controller_mc_pkg::*;
#(
   parameter int OP_WIDTH    = 6,
   parameter int ALUOP_WIDTH = 6
) (
   input  logic [OP_WIDTH-1:0]    opcode,
   output iclass_t                iclass,
   output logic [ALUOP_WIDTH-1:0] aluop,
   output logic                   alusrc,
   output logic                   is_signed,
   output logic                   br_eq,
   output logic [1:0]             size,
   output logic                   mem_signed,
   output logic                   illegal
);

   always_comb begin
      iclass     = CL_ILLEGAL;
      aluop      = '0;
      alusrc     = 1'b0;
      is_signed  = 1'b0;
      br_eq      = 1'b0;
      size       = SZ_BYTE;
      mem_signed = 1'b0;
      case (opcode)
         OP_WIDTH'(OP_RTYPE): iclass = CL_RTYPE;
         OP_WIDTH'(OP_J):     iclass = CL_J;
         OP_WIDTH'(OP_JAL):   iclass = CL_JAL;
         OP_WIDTH'(OP_BEQ), OP_WIDTH'(OP_BNE): begin
            iclass    = CL_BRANCH;
            aluop     = ALUOP_WIDTH'(FN_SUB);
            is_signed = 1'b1;
            br_eq     = (opcode == OP_WIDTH'(OP_BEQ));
         end
         // arithmetic immediates sign-extend, logical ones and lui zero-extend
         OP_WIDTH'(OP_ADDI):  begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_ADD);  alusrc = 1'b1; is_signed = 1'b1; end
         OP_WIDTH'(OP_ADDIU): begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_ADDU); alusrc = 1'b1; is_signed = 1'b1; end
         OP_WIDTH'(OP_SLTI):  begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_SLT);  alusrc = 1'b1; is_signed = 1'b1; end
         OP_WIDTH'(OP_SLTIU): begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_SLTU); alusrc = 1'b1; is_signed = 1'b1; end
         OP_WIDTH'(OP_ANDI):  begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_AND);  alusrc = 1'b1; end
         OP_WIDTH'(OP_ORI):   begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_OR);   alusrc = 1'b1; end
         OP_WIDTH'(OP_XORI):  begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_XOR);  alusrc = 1'b1; end
         OP_WIDTH'(OP_LUI):   begin iclass = CL_IMM; aluop = ALUOP_WIDTH'(FN_ADD);  alusrc = 1'b1; end
         OP_WIDTH'(OP_LW):  begin iclass = CL_LOAD;  size = SZ_WORD; mem_signed = 1'b1; end
         OP_WIDTH'(OP_LBU): begin iclass = CL_LOAD;  size = SZ_BYTE; end
         OP_WIDTH'(OP_LHU): begin iclass = CL_LOAD;  size = SZ_HALF; end
         OP_WIDTH'(OP_SB):  begin iclass = CL_STORE; size = SZ_BYTE; end
         OP_WIDTH'(OP_SH):  begin iclass = CL_STORE; size = SZ_HALF; end
         OP_WIDTH'(OP_SW):  begin iclass = CL_STORE; size = SZ_WORD; end
         default: ;
      endcase
      if (iclass == CL_LOAD || iclass == CL_STORE) begin
         aluop     = ALUOP_WIDTH'(FN_ADD);
         alusrc    = 1'b1;
         is_signed = 1'b1;
      end
      illegal = (iclass == CL_ILLEGAL);
   end

endmodule

// File: rtl/controller_mc.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// shared ready-handshaked memory port, with illegal-opcode and bus-timeout traps.
module controller_mc
   import controller_mc_pkg::*;
#(
   parameter int OP_WIDTH    = 6,
   parameter int ALUOP_WIDTH = 6,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [OP_WIDTH-1:0]      opcode,
   input  logic                     mem_ready,
   input  logic                     trap_ack,
   output logic [ALUOP_WIDTH-1:0]   ALUop,
   output logic                     regWrite,
   output logic                     regDest,
   output logic                     memToReg,
   output logic                     isSigned,
   output logic                     ALUsrc,
   output logic                     jump,
   output logic                     jal,
   output logic                     branch,
   output logic                     eq,
   output logic                     memRead,
   output logic                     memWrite,
   output logic                     memIsSigned,
   output logic [1:0]               memDataSize,
   output logic                     iorD,
   output logic                     irWrite,
   output logic                     pcWrite,
   output logic                     pcWriteCond,
   output logic                     pcExc,
   output logic                     trap,
   output logic [1:0]               trap_cause,
   output logic                     instr_done,
   output logic [2:0]               state,
   output logic [ALUOP_WIDTH+8:0]   combined
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               cause_q, cause_d;
   ctl_t                     ctl, ctl_o;
   logic [ALUOP_WIDTH-1:0]   alu_c;
   logic                     timeout;

   iclass_t                  dec_class;
   logic [ALUOP_WIDTH-1:0]   dec_aluop;
   logic                     dec_alusrc, dec_signed, dec_eq, dec_mem_signed, dec_illegal;
   logic [1:0]               dec_size;

   controller_mc_decode #(
      .OP_WIDTH    (OP_WIDTH),
      .ALUOP_WIDTH (ALUOP_WIDTH)
   ) u_decode (
      .opcode     (opcode),
      .iclass     (dec_class),
      .aluop      (dec_aluop),
      .alusrc     (dec_alusrc),
      .is_signed  (dec_signed),
      .br_eq      (dec_eq),
      .size       (dec_size),
      .mem_signed (dec_mem_signed),
      .illegal    (dec_illegal)
   );

   // A ready on the last allowed wait cycle completes the access instead of trapping.
   assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      ctl     = '0;
      alu_c   = '0;
      case (state_q)
         ST_FETCH: begin
            ctl.mem_read = 1'b1;
            ctl.mem_size = SZ_WORD;
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               state_d      = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (dec_illegal) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else if (dec_class == CL_J || dec_class == CL_JAL) begin
               ctl.jump       = 1'b1;
               ctl.jal        = (dec_class == CL_JAL);
               ctl.reg_write  = (dec_class == CL_JAL);
               ctl.pc_write   = 1'b1;
               ctl.instr_done = 1'b1;
               state_d        = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_c         = dec_aluop;
            ctl.alu_src   = dec_alusrc;
            ctl.is_signed = dec_signed;
            if (dec_class == CL_BRANCH) begin
               ctl.branch        = 1'b1;
               ctl.pc_write_cond = 1'b1;
               ctl.eq            = dec_eq;
               ctl.instr_done    = 1'b1;
               state_d           = ST_FETCH;
            end else if (dec_class == CL_LOAD || dec_class == CL_STORE) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            ctl.iord          = 1'b1;
            ctl.mem_size      = dec_size;
            ctl.mem_read      = (dec_class == CL_LOAD);
            ctl.mem_write     = (dec_class != CL_LOAD);
            ctl.mem_is_signed = (dec_class == CL_LOAD) && dec_mem_signed;
            if (mem_ready) begin
               ctl.instr_done = (dec_class != CL_LOAD);
               state_d        = (dec_class == CL_LOAD) ? ST_WB : ST_FETCH;
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dest   = (dec_class == CL_RTYPE);
            ctl.mem_to_reg = (dec_class == CL_LOAD);
            ctl.instr_done = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_TRAP: begin
            ctl.trap = 1'b1;
            if (trap_ack) begin
               ctl.pc_exc   = 1'b1;
               ctl.pc_write = 1'b1;
               cause_d      = CAUSE_NONE;
               state_d      = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   assign cnt_d = ((state_q == ST_FETCH || state_q == ST_MEM) && state_d == state_q)
                  ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // Reset blanks every output immediately, so an abandoned instruction commits nothing.
   assign ctl_o       = rst ? '0 : ctl;
   assign ALUop       = rst ? '0 : alu_c;
   assign trap_cause  = rst ? CAUSE_NONE : cause_q;
   assign state       = rst ? 3'd0 : state_q;
   assign regWrite    = ctl_o.reg_write;
   assign regDest     = ctl_o.reg_dest;
   assign memToReg    = ctl_o.mem_to_reg;
   assign isSigned    = ctl_o.is_signed;
   assign ALUsrc      = ctl_o.alu_src;
   assign jump        = ctl_o.jump;
   assign jal         = ctl_o.jal;
   assign branch      = ctl_o.branch;
   assign eq          = ctl_o.eq;
   assign memRead     = ctl_o.mem_read;
   assign memWrite    = ctl_o.mem_write;
   assign memIsSigned = ctl_o.mem_is_signed;
   assign memDataSize = ctl_o.mem_size;
   assign iorD        = ctl_o.iord;
   assign irWrite     = ctl_o.ir_write;
   assign pcWrite     = ctl_o.pc_write;
   assign pcWriteCond = ctl_o.pc_write_cond;
   assign pcExc       = ctl_o.pc_exc;
   assign trap        = ctl_o.trap;
   assign instr_done  = ctl_o.instr_done;
   assign combined    = {ALUop, regWrite, regDest, memToReg, isSigned, ALUsrc,
                         jump, branch, memRead, memWrite};

endmodule

// File: tb/tb_controller_mc.sv
// Bench for controller_mc: instruction-level timeline model, directed scenarios
// followed by a randomized instruction stream.
module tb_controller_mc;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'h00;
   logic        mem_ready = 1'b0;
   logic        trap_ack = 1'b0;
   logic [5:0]  ALUop;
   logic        regWrite, regDest, memToReg, isSigned, ALUsrc, jump, jal, branch, eq;
   logic        memRead, memWrite, memIsSigned, iorD, irWrite, pcWrite, pcWriteCond, pcExc, trap;
   logic        instr_done;
   logic [1:0]  memDataSize, trap_cause;
   logic [2:0]  state;
   logic [14:0] combined;

   controller_mc #(.OP_WIDTH(6), .ALUOP_WIDTH(6), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .trap_ack(trap_ack),
      .ALUop(ALUop), .regWrite(regWrite), .regDest(regDest), .memToReg(memToReg),
      .isSigned(isSigned), .ALUsrc(ALUsrc), .jump(jump), .jal(jal), .branch(branch), .eq(eq),
      .memRead(memRead), .memWrite(memWrite), .memIsSigned(memIsSigned),
      .memDataSize(memDataSize), .iorD(iorD), .irWrite(irWrite), .pcWrite(pcWrite),
      .pcWriteCond(pcWriteCond), .pcExc(pcExc), .trap(trap), .trap_cause(trap_cause),
      .instr_done(instr_done), .state(state), .combined(combined)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [5:0] alu;
      logic rw, rd, m2r, sgn, asrc, jmp, jl, br, eqv, mrd, mwr, msgn;
      logic [1:0] sz;
      logic iord, irw, pcw, pcwc, pcexc, trp;
      logic [1:0] cause;
      logic done;
   } exp_t;

   typedef struct {
      logic [5:0] op;
      logic       rdy;
      logic       ack;
      exp_t       e;
   } step_t;

   step_t q[$];
   int total = 0;
   int bad   = 0;

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.st = state;  o.alu = ALUop;
      o.rw = regWrite; o.rd = regDest; o.m2r = memToReg; o.sgn = isSigned; o.asrc = ALUsrc;
      o.jmp = jump; o.jl = jal; o.br = branch; o.eqv = eq;
      o.mrd = memRead; o.mwr = memWrite; o.msgn = memIsSigned; o.sz = memDataSize;
      o.iord = iorD; o.irw = irWrite; o.pcw = pcWrite; o.pcwc = pcWriteCond;
      o.pcexc = pcExc; o.trp = trap; o.cause = trap_cause; o.done = instr_done;
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [5:0] op, input logic rdy, input logic ack, input exp_t e);
      step_t s;
      s.op = op; s.rdy = rdy; s.ack = ack; s.e = e;
      q.push_back(s);
   endtask

   task automatic add_trap(input logic [5:0] op, input logic [1:0] cause, input int hold);
      exp_t e = blank(3'd5);
      e.trp = 1'b1;
      e.cause = cause;
      for (int i = 0; i < hold; i++) push(op, rbit(), 1'b0, e);
      e.pcexc = 1'b1;
      e.pcw = 1'b1;
      push(op, rbit(), 1'b1, e);
   endtask

   // One instruction as the controller should present it cycle by cycle:
   // fw / mw are the cycles memory stays busy in the fetch / data access.
   task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
      exp_t e;
      logic is_load, is_store;
      is_load  = (op == 6'h23 || op == 6'h24 || op == 6'h25);
      is_store = (op == 6'h28 || op == 6'h29 || op == 6'h2B);
      e = blank(3'd0);
      e.mrd = 1'b1;
      e.sz = 2'b10;
      for (int i = 0; i < fw && i < TMO; i++) push(6'($urandom), 1'b0, rbit(), e);
      if (fw >= TMO) begin
         add_trap(op, 2'b10, int'($urandom_range(0, 2)));
         return;
      end
      e.irw = 1'b1;
      e.pcw = 1'b1;
      push(6'($urandom), 1'b1, rbit(), e);

      e = blank(3'd1);
      if (op == 6'h02 || op == 6'h03) begin
         e.jmp = 1'b1; e.pcw = 1'b1; e.done = 1'b1;
         e.jl = (op == 6'h03);
         e.rw = (op == 6'h03);
         push(op, rbit(), rbit(), e);
         return;
      end
      if (!(op == 6'h00 || op == 6'h04 || op == 6'h05 || (op >= 6'h08 && op <= 6'h0F)
            || is_load || is_store)) begin
         push(op, rbit(), rbit(), e);
         add_trap(op, 2'b01, int'($urandom_range(0, 3)));
         return;
      end
      push(op, rbit(), rbit(), e);

      e = blank(3'd2);
      if (op == 6'h04 || op == 6'h05) begin
         e.alu = 6'h22; e.sgn = 1'b1; e.br = 1'b1; e.pcwc = 1'b1; e.done = 1'b1;
         e.eqv = (op == 6'h04);
         push(op, rbit(), rbit(), e);
         return;
      end
      if (op >= 6'h08 && op <= 6'h0F) begin
         case (op)
            6'h08: e.alu = 6'h20;
            6'h09: e.alu = 6'h21;
            6'h0A: e.alu = 6'h2A;
            6'h0B: e.alu = 6'h2B;
            6'h0C: e.alu = 6'h24;
            6'h0D: e.alu = 6'h25;
            6'h0E: e.alu = 6'h26;
            default: e.alu = 6'h20;
         endcase
         e.asrc = 1'b1;
         e.sgn = (op <= 6'h0B);
      end
      if (is_load || is_store) begin
         e.alu = 6'h20; e.asrc = 1'b1; e.sgn = 1'b1;
      end
      push(op, rbit(), rbit(), e);

      if (is_load || is_store) begin
         e = blank(3'd3);
         e.iord = 1'b1;
         e.mrd = is_load;
         e.mwr = is_store;
         e.sz = (op == 6'h24 || op == 6'h28) ? 2'b00 :
                (op == 6'h25 || op == 6'h29) ? 2'b01 : 2'b10;
         e.msgn = (op == 6'h23);
         for (int i = 0; i < mw && i < TMO; i++) push(op, 1'b0, rbit(), e);
         if (mw >= TMO) begin
            add_trap(op, 2'b10, int'($urandom_range(0, 2)));
            return;
         end
         e.done = is_store;
         push(op, 1'b1, rbit(), e);
         if (is_store) return;
      end

      e = blank(3'd4);
      e.rw = 1'b1;
      e.rd = (op == 6'h00);
      e.m2r = is_load;
      e.done = 1'b1;
      push(op, rbit(), rbit(), e);
   endtask

   // Entered and left on a falling edge; n < 0 drains the whole queue.
   task automatic run_steps(input int n);
      step_t s;
      int    left = n;
      while (q.size() > 0 && left != 0) begin
         s = q.pop_front();
         opcode = s.op;
         mem_ready = s.rdy;
         trap_ack = s.ack;
         #1;
         check($sformatf("st%0d_op%02h", s.e.st, s.op), 64'(observed()), 64'(s.e));
         check("combined", 64'(combined),
               64'({s.e.alu, s.e.rw, s.e.rd, s.e.m2r, s.e.sgn, s.e.asrc,
                    s.e.jmp, s.e.br, s.e.mrd, s.e.mwr}));
         @(negedge clk);
         left--;
      end
   endtask

   logic [5:0] legal [19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h24, 6'h25, 6'h28,
                              6'h29, 6'h2B};

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] rop;
      repeat (2) @(negedge clk);
      mem_ready = 1'b1;
      trap_ack = 1'b1;
      opcode = 6'h23;
      #1;
      check("reset_outputs", 64'(observed()), 64'(blank(3'd0)));
      check("reset_combined", 64'(combined), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      add_instr(6'h00, 0, 0);    // addu, zero wait
      add_instr(6'h25, 0, 3);    // lhu, three wait cycles in MEM
      add_instr(6'h04, 0, 0);    // beq
      add_instr(6'h05, 0, 0);    // bne
      add_instr(6'h3F, 0, 0);    // illegal
      add_instr(6'h02, 1, 0);    // j
      add_instr(6'h03, 0, 0);    // jal
      add_instr(6'h2B, 0, 40);   // sw, memory never answers
      add_instr(6'h23, 2, 14);   // lw, ready on the last allowed cycle
      add_instr(6'h0D, TMO, 0);  // fetch timeout
      add_instr(6'h28, 0, 0);    // sb
      run_steps(-1);

      // lw abandoned by reset while waiting in MEM
      add_instr(6'h23, 0, 6);
      run_steps(5);
      q.delete();
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("rst_in_mem", 64'(observed()), 64'(blank(3'd0)));
      @(negedge clk);
      #1;
      check("rst_held", 64'(observed()), 64'(blank(3'd0)));
      @(negedge clk);
      rst = 1'b0;
      add_instr(6'h23, 1, 0);
      run_steps(-1);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
         else rop = legal[$urandom_range(0, 18)];
         add_instr(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      run_steps(-1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
